msrv32_trap_controller: RTL and testbench

Machine-mode trap sequencer for the RV32I core; the initiating side of the CSR file's trap interface. It watches decoded exception flags, `mret`, and the interrupt enable/pending bits exported by the CSR file. It drives the CSR file's trap strobes (`set_epc`, `set_cause`, `mie_clear`, `mie_set`), the cause code, `instret_inc`, and the PC-source select and pipeline flush seen by the fetch stage.

---
 rtl/msrv32_pkg.sv | 47 ++++
 rtl/trap_priority_encoder.sv | 53 +++++
 rtl/msrv32_trap_controller.sv | 147 ++++++++++++++
 tb/tb_msrv32_trap_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// ---------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the msrv32 machine-mode trap logic:
//   - trap sequencer state encoding
//   - mcause codes for the interrupts and exceptions the core raises
//   - default PC-source select encodings seen by the fetch stage
//   - a helper that tells whether a latched cause needs an mtval capture
// ---------------------------------------------------------------------------
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_RESET       = 2'b00,
    ST_OPERATING   = 2'b01,
    ST_TRAP_TAKEN  = 2'b10,
    ST_TRAP_RETURN = 2'b11
  } trap_state_e;

  // Interrupt cause codes (mcause with interrupt bit set)
  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  // Exception cause codes (mcause with interrupt bit clear)
  localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK           = 4'd3;
  localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
  localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
  localparam logic [3:0] CAUSE_ECALL            = 4'd11;

  // PC mux select encodings
  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_NEXT = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_EPC  = 2'b11;

  // Misaligned-address exceptions are the only ones that load mtval with
  // the faulting address. Interrupt codes overlap numerically (MSI = 3,
  // MTI = 7 are harmless, but never treat an interrupt as misaligned).
  function automatic logic is_misaligned_cause(input logic [3:0] cause,
                                               input logic       is_irq);
    return !is_irq && (cause == CAUSE_MISALIGNED_INSTR ||
                       cause == CAUSE_MISALIGNED_LOAD  ||
                       cause == CAUSE_MISALIGNED_STORE);
  endfunction

endpackage

// File: rtl/trap_priority_encoder.sv
// ---------------------------------------------------------------------------
// trap_priority_encoder
// Purely combinational. Picks the single trap to take this cycle from the
// decoded exception flags and the already-enabled interrupt terms.
//   Inputs : misaligned_instr, illegal_instr, ebreak, ecall, misaligned_load,
//            misaligned_store (exception flags); ext_irq, sw_irq, tmr_irq
//            (pending & enabled & mstatus.MIE).
//   Outputs: trap_valid (any trap), cause[3:0] (mcause code), is_irq.
// Any interrupt beats any exception: the interrupted instruction has not
// retired and simply re-executes after MRET.
// ---------------------------------------------------------------------------
module trap_priority_encoder
  import msrv32_pkg::*;
(
  input  logic       misaligned_instr,
  input  logic       illegal_instr,
  input  logic       ebreak,
  input  logic       ecall,
  input  logic       misaligned_load,
  input  logic       misaligned_store,
  input  logic       ext_irq,
  input  logic       sw_irq,
  input  logic       tmr_irq,
  output logic       trap_valid,
  output logic [3:0] cause,
  output logic       is_irq
);

  logic any_irq;
  logic any_exc;

  assign any_irq    = ext_irq | sw_irq | tmr_irq;
  assign any_exc    = misaligned_instr | illegal_instr | ebreak | ecall |
                      misaligned_load | misaligned_store;
  assign trap_valid = any_irq | any_exc;
  assign is_irq     = any_irq;

  // NOTE: every path of a combinational block must assign its outputs;
  // the default up front keeps the if/else chain from inferring a latch.
  always_comb begin
    cause = CAUSE_MISALIGNED_INSTR;
    if      (ext_irq)          cause = CAUSE_MEI;
    else if (sw_irq)           cause = CAUSE_MSI;
    else if (tmr_irq)          cause = CAUSE_MTI;
    else if (misaligned_instr) cause = CAUSE_MISALIGNED_INSTR;
    else if (illegal_instr)    cause = CAUSE_ILLEGAL;
    else if (ebreak)           cause = CAUSE_EBREAK;
    else if (ecall)            cause = CAUSE_ECALL;
    else if (misaligned_load)  cause = CAUSE_MISALIGNED_LOAD;
    else if (misaligned_store) cause = CAUSE_MISALIGNED_STORE;
  end

endmodule

// File: rtl/msrv32_trap_controller.sv
// ---------------------------------------------------------------------------
// msrv32_trap_controller
// Machine-mode trap sequencer for the RV32I core. Watches exception flags,
// MRET and the CSR file's interrupt enable/pending bits; drives the CSR
// trap strobes, the cause code, the retire pulse, and the fetch-stage PC
// select and flush.
//   clk_in, rst_in (async, active low)
//   illegal_instr_in, misaligned_instr_in, misaligned_load_in,
//   misaligned_store_in, ecall_in, ebreak_in, mret_in   : decoded events
//   mie_in, meie_in/mtie_in/msie_in, meip_in/mtip_in/msip_in : CSR state
//   i_or_e_out, cause_out, misaligned_exception_out     : latched trap info
//   set_cause_out, set_epc_out, mie_clear_out, mie_set_out : CSR strobes
//   instret_inc_out, pc_src_out, flush_out, trap_taken_out
// State flow: RESET -> OPERATING; OPERATING -> TRAP_TAKEN on a trap, else
// -> TRAP_RETURN on MRET; both trap states return to OPERATING after one
// cycle. Cause fields are latched on entry to TRAP_TAKEN so the CSR file
// can form trap_address while TRAP_TAKEN is active.
// ---------------------------------------------------------------------------
module msrv32_trap_controller
  import msrv32_pkg::*;
#(
  parameter logic [1:0] BOOT_SEL = PC_SRC_BOOT,
  parameter logic [1:0] NEXT_SEL = PC_SRC_NEXT,
  parameter logic [1:0] TRAP_SEL = PC_SRC_TRAP,
  parameter logic [1:0] EPC_SEL  = PC_SRC_EPC
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       ecall_in,
  input  logic       ebreak_in,
  input  logic       mret_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       misaligned_exception_out,
  output logic       instret_inc_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       trap_taken_out
);

  trap_state_e state;

  logic       ext_irq;
  logic       sw_irq;
  logic       tmr_irq;
  logic       trap_valid;
  logic [3:0] trap_cause;
  logic       trap_is_irq;

  // Global MIE gates every interrupt source; after TRAP_TAKEN clears it,
  // a still-pending source cannot cause a nested trap.
  assign ext_irq = mie_in & meie_in & meip_in;
  assign sw_irq  = mie_in & msie_in & msip_in;
  assign tmr_irq = mie_in & mtie_in & mtip_in;

  trap_priority_encoder u_prio (
    .misaligned_instr (misaligned_instr_in),
    .illegal_instr    (illegal_instr_in),
    .ebreak           (ebreak_in),
    .ecall            (ecall_in),
    .misaligned_load  (misaligned_load_in),
    .misaligned_store (misaligned_store_in),
    .ext_irq          (ext_irq),
    .sw_irq           (sw_irq),
    .tmr_irq          (tmr_irq),
    .trap_valid       (trap_valid),
    .cause            (trap_cause),
    .is_irq           (trap_is_irq)
  );

  // State register plus the cause fields latched on trap entry.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state                    <= ST_RESET;
      cause_out                <= '0;
      i_or_e_out               <= 1'b0;
      misaligned_exception_out <= 1'b0;
    end else begin
      case (state)
        ST_RESET: state <= ST_OPERATING;
        ST_OPERATING: begin
          if (trap_valid) begin
            state                    <= ST_TRAP_TAKEN;
            cause_out                <= trap_cause;
            i_or_e_out               <= trap_is_irq;
            misaligned_exception_out <= is_misaligned_cause(trap_cause, trap_is_irq);
          end else if (mret_in) begin
            state <= ST_TRAP_RETURN;
          end
        end
        ST_TRAP_TAKEN:  state <= ST_OPERATING;
        ST_TRAP_RETURN: state <= ST_OPERATING;
        default:        state <= ST_RESET;
      endcase
    end
  end

  // Output decode from registered state; only instret_inc looks at inputs,
  // so a trapping instruction never reports retirement.
  always_comb begin
    pc_src_out      = BOOT_SEL;
    flush_out       = 1'b1;
    set_epc_out     = 1'b0;
    set_cause_out   = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    trap_taken_out  = 1'b0;
    instret_inc_out = 1'b0;
    case (state)
      ST_OPERATING: begin
        pc_src_out      = NEXT_SEL;
        flush_out       = 1'b0;
        instret_inc_out = !trap_valid;
      end
      ST_TRAP_TAKEN: begin
        pc_src_out     = TRAP_SEL;
        set_epc_out    = 1'b1;
        set_cause_out  = 1'b1;
        mie_clear_out  = 1'b1;
        trap_taken_out = 1'b1;
      end
      ST_TRAP_RETURN: begin
        pc_src_out  = EPC_SEL;
        mie_set_out = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_msrv32_trap_controller.sv
// ---------------------------------------------------------------------------
// tb_msrv32_trap_controller
// Directed bench for the trap sequencer. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_msrv32_trap_controller;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       illegal_instr_in, misaligned_instr_in, misaligned_load_in;
  logic       misaligned_store_in, ecall_in, ebreak_in, mret_in;
  logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
  logic       i_or_e_out;
  logic [3:0] cause_out;
  logic       set_cause_out, set_epc_out, mie_clear_out, mie_set_out;
  logic       misaligned_exception_out, instret_inc_out;
  logic [1:0] pc_src_out;
  logic       flush_out, trap_taken_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  msrv32_trap_controller dut (
    .clk_in                   (clk_in),
    .rst_in                   (rst_in),
    .illegal_instr_in         (illegal_instr_in),
    .misaligned_instr_in      (misaligned_instr_in),
    .misaligned_load_in       (misaligned_load_in),
    .misaligned_store_in      (misaligned_store_in),
    .ecall_in                 (ecall_in),
    .ebreak_in                (ebreak_in),
    .mret_in                  (mret_in),
    .mie_in                   (mie_in),
    .meie_in                  (meie_in),
    .mtie_in                  (mtie_in),
    .msie_in                  (msie_in),
    .meip_in                  (meip_in),
    .mtip_in                  (mtip_in),
    .msip_in                  (msip_in),
    .i_or_e_out               (i_or_e_out),
    .cause_out                (cause_out),
    .set_cause_out            (set_cause_out),
    .set_epc_out              (set_epc_out),
    .mie_clear_out            (mie_clear_out),
    .mie_set_out              (mie_set_out),
    .misaligned_exception_out (misaligned_exception_out),
    .instret_inc_out          (instret_inc_out),
    .pc_src_out               (pc_src_out),
    .flush_out                (flush_out),
    .trap_taken_out           (trap_taken_out)
  );

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic clear_inputs();
    illegal_instr_in = 0; misaligned_instr_in = 0; misaligned_load_in = 0;
    misaligned_store_in = 0; ecall_in = 0; ebreak_in = 0; mret_in = 0;
    mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0;
    meip_in = 0; mtip_in = 0; msip_in = 0;
  endtask

  // Advance one full cycle: the rising edge happens in between.
  task automatic next_cycle();
    @(negedge clk_in);
    #1;
  endtask

  // Check the full output set of the TRAP_TAKEN cycle.
  task automatic check_trap(input string tag, input logic [3:0] cause,
                            input logic irq, input logic mis);
    check({tag, ".trap_taken"}, trap_taken_out, 1);
    check({tag, ".set_epc"},    set_epc_out, 1);
    check({tag, ".set_cause"},  set_cause_out, 1);
    check({tag, ".mie_clear"},  mie_clear_out, 1);
    check({tag, ".mie_set"},    mie_set_out, 0);
    check({tag, ".pc_src"},     pc_src_out, 2'b10);
    check({tag, ".flush"},      flush_out, 1);
    check({tag, ".cause"},      cause_out, cause);
    check({tag, ".i_or_e"},     i_or_e_out, irq);
    check({tag, ".misaligned"}, misaligned_exception_out, mis);
  endtask

  // Check the OPERATING cycle that follows a trap or return.
  task automatic check_back(input string tag);
    check({tag, ".back_pc_src"},  pc_src_out, 2'b01);
    check({tag, ".back_flush"},   flush_out, 0);
    check({tag, ".back_taken"},   trap_taken_out, 0);
    check({tag, ".back_instret"}, instret_inc_out, 1);
  endtask

  // Apply one exception-only event in OPERATING and follow it through.
  task automatic exc_case(input string tag, input logic [5:0] flags,
                          input logic [3:0] cause, input logic mis);
    {misaligned_instr_in, illegal_instr_in, ebreak_in, ecall_in,
     misaligned_load_in, misaligned_store_in} = flags;
    #1;
    check({tag, ".instret_detect"}, instret_inc_out, 0);
    next_cycle();
    clear_inputs();
    #1;
    check_trap(tag, cause, 1'b0, mis);
    next_cycle();
    check_back(tag);
    check({tag, ".cause_hold"}, cause_out, cause);
  endtask

  initial begin
    clear_inputs();
    rst_in = 0;
    #12;
    check("rst.pc_src",    pc_src_out, 2'b00);
    check("rst.flush",     flush_out, 1);
    check("rst.cause",     cause_out, 0);
    check("rst.i_or_e",    i_or_e_out, 0);
    check("rst.instret",   instret_inc_out, 0);
    check("rst.set_epc",   set_epc_out, 0);

    // Release reset at a falling edge: RESET for one more cycle.
    @(negedge clk_in);
    rst_in = 1;
    #1;
    check("rel.pc_src", pc_src_out, 2'b00);
    check("rel.flush",  flush_out, 1);
    next_cycle();
    check("op.pc_src",  pc_src_out, 2'b01);
    check("op.flush",   flush_out, 0);
    check("op.instret", instret_inc_out, 1);

    // Exceptions: flags = {mis_instr, illegal, ebreak, ecall, mis_load, mis_store}
    exc_case("ecall",       6'b000100, 4'd11, 1'b0);
    exc_case("mis_load",    6'b000010, 4'd4,  1'b1);
    exc_case("ebreak",      6'b001000, 4'd3,  1'b0);
    exc_case("mis_store",   6'b000001, 4'd6,  1'b1);
    exc_case("ecall_store", 6'b000101, 4'd11, 1'b0);
    exc_case("all_exc",     6'b111111, 4'd0,  1'b1);
    exc_case("ill_ebrk",    6'b011000, 4'd2,  1'b0);

    // All interrupts plus an illegal instruction: external wins.
    mie_in = 1; meie_in = 1; meip_in = 1; msie_in = 1; msip_in = 1;
    mtie_in = 1; mtip_in = 1; illegal_instr_in = 1;
    #1;
    check("irq_all.instret_detect", instret_inc_out, 0);
    next_cycle();
    clear_inputs();
    #1;
    check_trap("irq_all", 4'd11, 1'b1, 1'b0);
    next_cycle();
    check_back("irq_all");

    // Software beats timer.
    mie_in = 1; msie_in = 1; msip_in = 1; mtie_in = 1; mtip_in = 1;
    next_cycle();
    clear_inputs();
    #1;
    check_trap("irq_sw", 4'd3, 1'b1, 1'b0);
    next_cycle();

    // Timer alone.
    mie_in = 1; mtie_in = 1; mtip_in = 1;
    next_cycle();
    clear_inputs();
    #1;
    check_trap("irq_tmr", 4'd7, 1'b1, 1'b0);
    next_cycle();

    // Pending and enabled but globally masked: no trap, instruction retires.
    meie_in = 1; meip_in = 1; msie_in = 1; msip_in = 1;
    #1;
    check("masked.instret", instret_inc_out, 1);
    next_cycle();
    check("masked.taken",   trap_taken_out, 0);
    check("masked.pc_src",  pc_src_out, 2'b01);
    check("masked.cause",   cause_out, 7);
    check("masked.i_or_e",  i_or_e_out, 1);
    clear_inputs();

    // MRET alone.
    mret_in = 1;
    next_cycle();
    clear_inputs();
    #1;
    check("mret.mie_set",   mie_set_out, 1);
    check("mret.pc_src",    pc_src_out, 2'b11);
    check("mret.flush",     flush_out, 1);
    check("mret.set_epc",   set_epc_out, 0);
    check("mret.mie_clear", mie_clear_out, 0);
    check("mret.taken",     trap_taken_out, 0);
    next_cycle();
    check_back("mret");
    check("mret.mie_set_off", mie_set_out, 0);

    // MRET with an illegal instruction: the trap wins.
    mret_in = 1; illegal_instr_in = 1;
    next_cycle();
    clear_inputs();
    #1;
    check_trap("mret_ill", 4'd2, 1'b0, 1'b0);
    next_cycle();

    // Asynchronous reset in the middle of TRAP_TAKEN.
    misaligned_load_in = 1;
    next_cycle();
    clear_inputs();
    #1;
    check("arst.pre_taken", trap_taken_out, 1);
    #1;
    rst_in = 0;
    #1;
    check("arst.set_epc",    set_epc_out, 0);
    check("arst.set_cause",  set_cause_out, 0);
    check("arst.mie_clear",  mie_clear_out, 0);
    check("arst.taken",      trap_taken_out, 0);
    check("arst.pc_src",     pc_src_out, 2'b00);
    check("arst.flush",      flush_out, 1);
    check("arst.cause",      cause_out, 0);
    check("arst.misaligned", misaligned_exception_out, 0);
    check("arst.instret",    instret_inc_out, 0);
    next_cycle();
    check("arst.held", pc_src_out, 2'b00);
    @(negedge clk_in);
    rst_in = 1;
    next_cycle();
    check("arst.recover", pc_src_out, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
